// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access stage: access sizes, FSM states
// and the bus-timeout counter width.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TMO_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane former: byte enables, lane-replicated store data and the
// misalignment flag for a given size and low address bits.
module store_lane_gen
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    // Lane selection and alignment check by access size
    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                o_misaligned = 1'b0;
            end
            SZ_HALF: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_misaligned = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: alignment check, req/gnt/rvalid bus handshake with
// timeout, pipeline stall, and latched load info for the split_byte stage.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_word,
    output logic [31:0] load_addr,
    output logic [1:0]  load_size,
    output logic        load_sign,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic [31:0] bad_vaddr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [31:0]       r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_load_word;
    logic [TMO_W-1:0]  r_cnt;
    logic              r_exc_bus;

    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misaligned;
    logic              w_idle;
    logic              w_live_req;
    logic              w_accept;
    logic              w_exc;
    logic              w_tmo;
    logic              w_capture;
    logic              w_timeout;

    store_lane_gen u_lane (
        .i_size       (req_size),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned)
    );

    assign w_idle     = (r_state == ST_IDLE);
    assign w_live_req = w_idle & req_valid & ~flush;
    assign w_accept   = w_live_req & ~w_misaligned;
    assign w_exc      = w_live_req & w_misaligned;
    assign w_tmo      = (r_cnt == TMO_LAST);

    // Next-state logic; gnt/rvalid win over a same-cycle flush
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_REQ;
                else          w_next = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    w_next = r_we ? ST_DONE : ST_WAIT;
                end else if (flush) begin
                    w_next = ST_IDLE;
                end else if (w_tmo) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_next    = ST_DONE;
                    w_capture = 1'b1;
                end else if (flush) begin
                    w_next = ST_DRAIN;
                end else if (w_tmo) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) w_next = ST_IDLE;
                else            w_next = ST_DRAIN;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Request latch at accept; loads carry zero write data on the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_addr  <= 32'h0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_sign  <= req_sign;
            r_addr  <= req_addr;
            r_be    <= w_be;
            r_wdata <= req_we ? w_wdata : 32'h0;
        end
    end

    // Timeout counter spans REQ and WAIT together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_cnt <= '0;
        else if (w_accept)                                   r_cnt <= '0;
        else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) r_cnt <= r_cnt + TMO_W'(1);
    end

    // Completion data: captured read word, or zero with bus error on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_word <= 32'h0;
            r_exc_bus   <= 1'b0;
        end else begin
            if (w_capture)      r_load_word <= mem_rdata;
            else if (w_timeout) r_load_word <= 32'h0;
            if ((r_state == ST_REQ) || (r_state == ST_WAIT)) r_exc_bus <= w_timeout;
        end
    end

    assign stall     = w_accept | (r_state == ST_REQ) | (r_state == ST_WAIT) | (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign exc_bus   = (r_state == ST_DONE) & r_exc_bus;
    assign exc_adel  = w_exc & ~req_we;
    assign exc_ades  = w_exc & req_we;
    assign bad_vaddr = w_exc ? req_addr : 32'h0;
    assign load_word = r_load_word;
    assign load_addr = r_addr;
    assign load_size = r_size;
    assign load_sign = r_sign;
    assign mem_req   = (r_state == ST_REQ);
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a short bus timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        stall, done, load_sign, exc_adel, exc_ades, exc_bus;
    logic        mem_req, mem_we;
    logic [31:0] load_word, load_addr, bad_vaddr, mem_addr, mem_wdata;
    logic [1:0]  load_size;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .stall(stall), .done(done),
        .load_word(load_word), .load_addr(load_addr), .load_size(load_size),
        .load_sign(load_sign), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_bus(exc_bus), .bad_vaddr(bad_vaddr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
        checks++; if (load_word !== 32'h0) begin errors++; $display("FAIL rst_load_word got %h exp 0", load_word); end
        checks++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL rst_mem_be got %b exp 0000", mem_be); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_accept_stall got %0b exp 1", stall); end
        tick();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_mem_req got %0b exp 1", mem_req); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", mem_be); end
        checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h exp ababab ab", mem_wdata); end
        checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", mem_addr); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_we got %0b exp 1", mem_we); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done got %0b exp 1", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_done_stall got %0b exp 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_req_drop got %0b exp 0", mem_req); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sb_done_pulse got %0b exp 0", done); end
    endtask

    task automatic test_load_half();
        issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b exp 1100", mem_be); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL lh_wdata got %h exp 0", mem_wdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lh_we got %0b exp 0", mem_we); end
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lh_wait%0d stall %0b done %0b exp 1 0", i, stall, done); end
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lh_done got %0b exp 1", done); end
        checks++; if (load_word !== 32'h8001_1234) begin errors++; $display("FAIL lh_word got %h exp 80011234", load_word); end
        checks++; if (load_addr !== 32'h0000_2002) begin errors++; $display("FAIL lh_addr got %h exp 00002002", load_addr); end
        checks++; if (load_size !== 2'b01 || load_sign !== 1'b1) begin errors++; $display("FAIL lh_size_sign got %b %0b exp 01 1", load_size, load_sign); end
        tick();
    endtask

    task automatic test_misaligned();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0);
        #1;
        checks++; if (exc_adel !== 1'b1 || exc_ades !== 1'b0) begin errors++; $display("FAIL mis_adel got %0b %0b exp 1 0", exc_adel, exc_ades); end
        checks++; if (bad_vaddr !== 32'h0000_3001) begin errors++; $display("FAIL mis_vaddr got %h exp 00003001", bad_vaddr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %0b exp 0", stall); end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req got %0b exp 0", mem_req); end
        issue(1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h1234);
        #1;
        checks++; if (exc_ades !== 1'b1 || exc_adel !== 1'b0) begin errors++; $display("FAIL mis_ades got %0b %0b exp 1 0", exc_ades, exc_adel); end
        issue(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0);
        #1;
        checks++; if (exc_adel !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL mis_byte_ok adel %0b stall %0b exp 0 1", exc_adel, stall); end
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || exc_adel !== 1'b0) begin errors++; $display("FAIL mis_flush stall %0b adel %0b exp 0 0", stall, exc_adel); end
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_still_idle got %0b exp 0", mem_req); end
    endtask

    task automatic test_timeout();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_req%0d req %0b done %0b exp 1 0", i, mem_req, done); end
            tick();
        end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %0b exp 0", mem_req); end
        checks++; if (done !== 1'b1 || exc_bus !== 1'b1) begin errors++; $display("FAIL to_done_bus got %0b %0b exp 1 1", done, exc_bus); end
        checks++; if (load_word !== 32'h0) begin errors++; $display("FAIL to_word got %h exp 0", load_word); end
        tick();
        checks++; if (exc_bus !== 1'b0) begin errors++; $display("FAIL to_bus_pulse got %0b exp 0", exc_bus); end
    endtask

    task automatic test_flush_wait();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1 || load_word !== 32'h1234_5678) begin errors++; $display("FAIL fw_pre done %0b word %h exp 1 12345678", done, load_word); end
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fw_drain stall %0b done %0b exp 1 0", stall, done); end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL fw_idle done %0b stall %0b exp 0 0", done, stall); end
        checks++; if (load_word !== 32'h1234_5678) begin errors++; $display("FAIL fw_word got %h exp 12345678", load_word); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fw_no_done got %0b exp 0", done); end
    endtask

    task automatic test_reset_mid_wait();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_ctl stall %0b req %0b done %0b exp 0 0 0", stall, mem_req, done); end
        checks++; if (load_word !== 32'h0 || load_addr !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rm_data word %h addr %h maddr %h exp 0", load_word, load_addr, mem_addr); end
        #3;
        rst_n = 1'b1;
        tick();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6008, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1 || load_word !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_after done %0b word %h exp 1 cafef00d", done, load_word); end
        checks++; if (load_addr !== 32'h0000_6008) begin errors++; $display("FAIL rm_after_addr got %h exp 00006008", load_addr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_timeout();
        test_flush_wait();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory access stage between the MEM pipeline stage and the data-memory bus; feeds the split_byte load-extraction stage directly downstream.
Checks access alignment and forms byte enables and lane-replicated store data. Runs a req/gnt/rvalid bus handshake, stalling the pipeline until the access completes.
Presents the raw 32-bit read word plus the latched addr/size/sign to split_byte for lane selection and extension.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before a bus-error completion (1..255; 8-bit counter).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage holds a load/store
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10/11 word
req_sign  in  1  load sign-extend (passed through)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
flush  in  1  cancel current/pending access
stall  out  1  hold the pipeline
done  out  1  one-cycle completion pulse
load_word  out  32  raw captured word (to split_byte data_in)
load_addr  out  32  latched address (to split_byte addr_in)
load_size  out  2  latched size
load_sign  out  1  latched sign
exc_adel  out  1  misaligned load
exc_ades  out  1  misaligned store
exc_bus  out  1  bus timeout, pulses with done
bad_vaddr  out  32  faulting address
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_be  out  4  byte enables
mem_addr  out  32  word address, [1:0] forced 00
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0, all registered outputs 0.
- FSM states: IDLE, REQ, WAIT, DRAIN, DONE.
- Alignment (combinational, IDLE only):
  - half misaligned when addr[0]=1; word misaligned when addr[1:0]!=00; byte never misaligned.
  - On misalignment with req_valid & !flush: exc_adel (load) or exc_ades (store) high the same cycle, bad_vaddr=req_addr, stall=0, no bus access, stay IDLE.
- Lanes:
  - byte: be=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - half: be=addr[1]?1100:0011, wdata={2{d[15:0]}}.
  - word: be=1111, wdata=d.
  - Loads drive the same be with mem_wdata=0.
- stall = (IDLE & req_valid & aligned & !flush) | REQ | WAIT | DRAIN. Deasserted in DONE.
- IDLE -> REQ on an aligned req_valid & !flush. Latch we/size/sign/addr, be and wdata at that edge; counter cleared.
- REQ:
  - mem_req=1; mem_addr/be/we/wdata held stable until gnt.
  - gnt & store -> DONE. gnt & load -> WAIT.
  - flush before gnt -> IDLE; mem_req drops next cycle, no done.
- WAIT:
  - mem_rvalid -> latch mem_rdata into load_word, go DONE.
  - flush -> DRAIN.
  - rvalid in the same cycle as a gnt is not accepted; rvalid is earliest one cycle after gnt.
- DRAIN: wait for mem_rvalid, discard data, -> IDLE, no done.
- Timeout:
  - Counter increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES -> DONE with exc_bus=1 and load_word=0.
  - In REQ, mem_req drops on that timeout.
- DONE (exactly one cycle):
  - done=1; load_* valid and held until the next accept.
  - Requests are ignored because the pipeline advances at this edge. -> IDLE.
- Latency, zero-wait bus (gnt in first REQ cycle, rvalid next): store done 2 cycles after accept, load done 3 cycles after accept.
- flush has priority over gnt/rvalid only where stated; flush in DONE has no effect.

Decomposition:
- Shared package: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), FSM state encoding, TIMEOUT counter width.
- One natural sub-module, store_lane_gen: combinational size/addr/wdata -> be/wdata/misaligned. It is reusable by the I/O path.

Test Plan:
- Store byte, addr 0x1003, wdata 0x000000AB, gnt immediate -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000; done 2 cycles after accept.
- Load half, addr 0x2002, rvalid 3 cycles after gnt with rdata 0x8001_1234 -> stall held; done with load_word=0x80011234, load_addr=0x2002, load_size=01.
- Load word at 0x3001 -> exc_adel=1 and bad_vaddr=0x3001 the same cycle; stall=0, mem_req never asserted. Store half at 0x3001 -> exc_ades=1.
- Load with gnt never asserted, TIMEOUT_CYCLES=8 -> mem_req drops after 8 cycles; done & exc_bus pulse together, load_word=0.
- Load granted, flush in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> no done, load_word unchanged, FSM back to IDLE.
- rst_n low mid-WAIT -> all outputs 0 immediately; a following load completes normally.
